// File: rtl/spi_master_io_ctrl.sv
// SPI master IO sequencer: pops bytes from a first-word-fall-through FIFO,
// shifts them out on MOSI with a programmable SCLK (modes 0-3), assembles
// MISO into received bytes and keeps SS low across back-to-back bytes.
module spi_master_io_ctrl #(
    parameter int SW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spi_en,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          lsbfirst,
    input  logic [DW-1:0] clkdiv,
    input  logic          fifo_empty,
    input  logic [SW-1:0] fifo_dout,
    output logic          fifo_read,
    output logic          sclk,
    output logic          mosi,
    output logic          ss,
    input  logic          miso,
    output logic          rx_access,
    output logic [SW-1:0] rx_data,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SETUP, DATA, HOLD} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_q;
    logic          cpol_q;
    logic          cpha_q;
    logic          lsb_q;
    logic [3:0]    edge_cnt;
    logic [SW-1:0] tx_sh;
    logic [SW-1:0] rx_sh;

    logic          tick;
    logic          leading;
    logic          last_edge;
    logic          can_pop;
    logic          sample_now;
    logic          advance_now;
    logic [SW-1:0] rx_next;

    // Bit that leaves the shift register next, given the bit order.
    function automatic logic head_bit(input logic [SW-1:0] v, input logic lsb);
        return lsb ? v[0] : v[SW-1];
    endfunction

    // Shift register contents after the head bit has been sent.
    function automatic logic [SW-1:0] shift_out(input logic [SW-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[SW-1:1]} : {v[SW-2:0], 1'b0};
    endfunction

    // Half-period tick, edge classification and the receive shifter's next value.
    always_comb begin
        tick        = (div_cnt == div_q);
        leading     = ~edge_cnt[0];
        last_edge   = (edge_cnt == 4'd15);
        can_pop     = spi_en & ~fifo_empty;
        sample_now  = (state == DATA) && tick && (leading ^ cpha_q);
        advance_now = (state == DATA) && tick &&
                      (cpha_q ? leading : (!leading && !last_edge));
        rx_next     = rx_sh;
        if (sample_now) begin
            rx_next = lsb_q ? {miso, rx_sh[SW-1:1]} : {rx_sh[SW-2:0], miso};
        end
    end

    // Frame sequencer with registered pin outputs and FIFO/receive strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            edge_cnt  <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            fifo_read <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss        <= 1'b1;
            rx_access <= 1'b0;
            rx_data   <= '0;
            busy      <= 1'b0;
        end else begin
            fifo_read <= 1'b0;
            rx_access <= 1'b0;
            rx_sh     <= rx_next;
            if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
            end
            case (state)
                IDLE: begin
                    ss      <= 1'b1;
                    sclk    <= cpol_q;
                    mosi    <= 1'b0;
                    busy    <= 1'b0;
                    div_cnt <= '0;
                    if (can_pop) begin
                        fifo_read <= 1'b1;
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        lsb_q     <= lsbfirst;
                        div_q     <= clkdiv;
                        sclk      <= cpol;
                        ss        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                        if (!cpha) begin
                            mosi  <= head_bit(fifo_dout, lsbfirst);
                            tx_sh <= shift_out(fifo_dout, lsbfirst);
                        end else begin
                            tx_sh <= fifo_dout;
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        edge_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        if (advance_now) begin
                            mosi  <= head_bit(tx_sh, lsb_q);
                            tx_sh <= shift_out(tx_sh, lsb_q);
                        end
                        if (last_edge) begin
                            rx_access <= 1'b1;
                            rx_data   <= rx_next;
                            if (can_pop) begin
                                fifo_read <= 1'b1;
                                edge_cnt  <= '0;
                                if (!cpha_q) begin
                                    mosi  <= head_bit(fifo_dout, lsb_q);
                                    tx_sh <= shift_out(fifo_dout, lsb_q);
                                end else begin
                                    tx_sh <= fifo_dout;
                                end
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            edge_cnt <= edge_cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    sclk <= cpol_q;
                    if (tick) begin
                        ss    <= 1'b1;
                        mosi  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_io_ctrl.sv
// Self-checking bench for spi_master_io_ctrl: a FIFO model feeds the master,
// a pin-level SPI slave model reconstructs MOSI bytes and drives MISO, and
// frame-level expectations come from plain timing arithmetic.
module tb_spi_master_io_ctrl;

    localparam int SW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spi_en = 1'b0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          lsbfirst = 1'b0;
    logic [DW-1:0] clkdiv = '0;
    logic          fifo_empty = 1'b1;
    logic [SW-1:0] fifo_dout = '0;
    logic          fifo_read;
    logic          sclk;
    logic          mosi;
    logic          ss;
    logic          miso = 1'b0;
    logic          rx_access;
    logic [SW-1:0] rx_data;
    logic          busy;

    spi_master_io_ctrl #(.SW(SW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .spi_en(spi_en), .cpol(cpol), .cpha(cpha),
        .lsbfirst(lsbfirst), .clkdiv(clkdiv), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_read(fifo_read), .sclk(sclk), .mosi(mosi),
        .ss(ss), .miso(miso), .rx_access(rx_access), .rx_data(rx_data), .busy(busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // FIFO contents, slave transmit bytes and everything observed on the pins
    logic [7:0] fifo_q[$];
    logic [7:0] slave_q[$];
    logic [7:0] rx_seen[$];
    logic [7:0] mosi_bytes[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_slave[$];
    int         read_offs[$];
    int         rx_offs[$];

    int   cyc = 0;
    int   frame_start = 0;
    int   ss_low_cnt = 0;
    int   last_ss_low = 0;
    int   edges = 0;
    int   last_edges = 0;
    int   frames_done = 0;
    int   reads = 0;
    logic ss_prev = 1'b1;
    logic sclk_prev = 1'b0;
    logic fr_cpha = 1'b0;
    logic fr_lsb = 1'b0;
    logic loopback = 1'b1;
    logic [7:0] acc = '0;
    int   mk, mb, me;
    logic [7:0] mtmp;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       lsb;
        int         div;
        logic [7:0] tx;
        logic       loop;
        logic [7:0] slave;
        logic [7:0] exp_rx;
        int         exp_ss;
    } vec_t;

    vec_t vecs[6];

    // Single comparison point: counts, and reports a mismatch on one line
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present the FIFO head to the DUT
    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endtask

    // Frame configuration inputs
    task automatic applyStimulus(input logic c_pol, input logic c_pha, input logic c_lsb, input int div);
        cpol     = c_pol;
        cpha     = c_pha;
        lsbfirst = c_lsb;
        clkdiv   = DW'(div);
    endtask

    // Pin monitor, FIFO pop model and SPI slave; runs on the falling edge so
    // every DUT output it looks at has settled since the rising edge.
    always @(negedge clk) begin
        cyc++;
        if (ss_prev && !ss) begin
            frame_start = cyc;
            fr_cpha     = cpha;
            fr_lsb      = lsbfirst;
            edges       = 0;
            acc         = '0;
            ss_low_cnt  = 0;
        end
        if (!ss) ss_low_cnt++;
        if (!ss_prev && ss) begin
            last_ss_low = ss_low_cnt;
            last_edges  = edges;
            frames_done++;
            edges       = 0;
            acc         = '0;
            ss_low_cnt  = 0;
        end
        if (!ss && !ss_prev && (sclk !== sclk_prev)) begin
            mk = edges % 16;
            if (((mk % 2) == 0) == (fr_cpha == 1'b0)) begin
                mb = mk / 2;
                if (fr_lsb) acc[mb] = mosi;
                else        acc[7-mb] = mosi;
            end
            edges++;
            if ((edges % 16) == 0) begin
                mosi_bytes.push_back(acc);
                acc = '0;
                if (slave_q.size() != 0) void'(slave_q.pop_front());
            end
        end
        if (fifo_read) begin
            checkOutput("pop_when_nonempty", int'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            reads++;
            read_offs.push_back(cyc - frame_start);
        end
        refresh_fifo();
        if (rx_access) begin
            rx_seen.push_back(rx_data);
            rx_offs.push_back(cyc - frame_start);
        end
        if (loopback) begin
            miso = mosi;
        end else begin
            me = edges % 16;
            if (slave_q.size() == 0 || (fr_cpha && me == 0)) begin
                miso = 1'b0;
            end else begin
                mb   = fr_cpha ? (me - 1) / 2 : me / 2;
                mtmp = slave_q[0];
                miso = fr_lsb ? mtmp[mb] : mtmp[7-mb];
            end
        end
        ss_prev   = ss;
        sclk_prev = sclk;
    end

    // Bounded wait for the end of the current/next SS frame
    task automatic wait_frame(input string tag, input int limit);
        int start;
        start = frames_done;
        for (int i = 0; i < limit && frames_done == start; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput({tag, ".frame_end"}, frames_done - start, 1);
    endtask

    // Bounded wait until the slave has seen n SCLK edges in this frame
    task automatic wait_edges(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && edges < n; i++) @(negedge clk);
        checkOutput({tag, ".reach_edge"}, int'(edges >= n), 1);
    endtask

    // Load FIFO and slave from exp_tx/exp_slave and clear the observations
    task automatic setup_frame(input logic c_pol, input logic c_pha, input logic c_lsb,
                               input int div, input logic loop);
        @(negedge clk);
        applyStimulus(c_pol, c_pha, c_lsb, div);
        loopback = loop;
        rx_seen.delete();
        mosi_bytes.delete();
        read_offs.delete();
        rx_offs.delete();
        slave_q.delete();
        reads = 0;
        foreach (exp_slave[i]) slave_q.push_back(exp_slave[i]);
        foreach (exp_tx[i]) push_byte(exp_tx[i]);
        @(negedge clk);
    endtask

    // One complete frame of exp_tx.size() bytes, checked against the timing model:
    // SS low (2+16N) half-periods, pop k at (1+16k) half-periods (k>0),
    // rx_access k at (17+16k) half-periods, all measured from SS falling.
    task automatic run_frame(input string tag, input logic c_pol, input logic c_pha,
                             input logic c_lsb, input int div, input logic loop);
        int n, h, exp_rd;
        n = exp_tx.size();
        h = div + 1;
        setup_frame(c_pol, c_pha, c_lsb, div, loop);
        spi_en = 1'b1;
        wait_frame(tag, 1000);
        spi_en = 1'b0;
        checkOutput({tag, ".ss_low"}, last_ss_low, (2 + 16 * n) * h);
        checkOutput({tag, ".edges"}, last_edges, 16 * n);
        checkOutput({tag, ".reads"}, reads, n);
        checkOutput({tag, ".rx_count"}, rx_seen.size(), n);
        for (int k = 0; k < n; k++) begin
            exp_rd = loop ? int'(exp_tx[k]) : int'(exp_slave[k]);
            checkOutput($sformatf("%s.rx%0d", tag, k),
                        (k < rx_seen.size()) ? int'(rx_seen[k]) : -1, exp_rd);
            checkOutput($sformatf("%s.mosi%0d", tag, k),
                        (k < mosi_bytes.size()) ? int'(mosi_bytes[k]) : -1, int'(exp_tx[k]));
            checkOutput($sformatf("%s.pop_at%0d", tag, k),
                        (k < read_offs.size()) ? read_offs[k] : -1, (k == 0) ? 0 : (1 + 16 * k) * h);
            checkOutput($sformatf("%s.rx_at%0d", tag, k),
                        (k < rx_offs.size()) ? rx_offs[k] : -1, (17 + 16 * k) * h);
        end
        checkOutput({tag, ".idle_sclk"}, int'(sclk), int'(c_pol));
        checkOutput({tag, ".idle_busy"}, int'(busy), 0);
        checkOutput({tag, ".idle_ss"}, int'(ss), 1);
    endtask

    // Watchdog against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        vecs[0] = '{cpol:1'b0, cpha:1'b0, lsb:1'b0, div:1, tx:8'hA5, loop:1'b1, slave:8'h00, exp_rx:8'hA5, exp_ss:36};
        vecs[1] = '{cpol:1'b0, cpha:1'b1, lsb:1'b1, div:0, tx:8'h3C, loop:1'b1, slave:8'h00, exp_rx:8'h3C, exp_ss:18};
        vecs[2] = '{cpol:1'b1, cpha:1'b0, lsb:1'b1, div:0, tx:8'h3C, loop:1'b1, slave:8'h00, exp_rx:8'h3C, exp_ss:18};
        vecs[3] = '{cpol:1'b1, cpha:1'b1, lsb:1'b1, div:0, tx:8'h3C, loop:1'b1, slave:8'h00, exp_rx:8'h3C, exp_ss:18};
        vecs[4] = '{cpol:1'b0, cpha:1'b0, lsb:1'b1, div:3, tx:8'h5A, loop:1'b0, slave:8'h96, exp_rx:8'h96, exp_ss:72};
        vecs[5] = '{cpol:1'b1, cpha:1'b1, lsb:1'b0, div:2, tx:8'hC3, loop:1'b0, slave:8'h2D, exp_rx:8'h2D, exp_ss:54};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst.ss", int'(ss), 1);
        checkOutput("rst.sclk", int'(sclk), 0);
        checkOutput("rst.mosi", int'(mosi), 0);
        checkOutput("rst.fifo_read", int'(fifo_read), 0);
        checkOutput("rst.rx_access", int'(rx_access), 0);
        checkOutput("rst.rx_data", int'(rx_data), 0);
        checkOutput("rst.busy", int'(busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single-byte frames in each mode from the vector table
        for (int v = 0; v < 6; v++) begin
            exp_tx.delete();
            exp_slave.delete();
            exp_tx.push_back(vecs[v].tx);
            exp_slave.push_back(vecs[v].slave);
            run_frame($sformatf("vec%0d", v), vecs[v].cpol, vecs[v].cpha, vecs[v].lsb,
                      vecs[v].div, vecs[v].loop);
            checkOutput($sformatf("vec%0d.tbl_rx", v),
                        (rx_seen.size() != 0) ? int'(rx_seen[0]) : -1, int'(vecs[v].exp_rx));
            checkOutput($sformatf("vec%0d.tbl_ss", v), last_ss_low, vecs[v].exp_ss);
        end

        // Three back-to-back bytes in one frame
        exp_tx    = '{8'h01, 8'h80, 8'hFF};
        exp_slave.delete();
        run_frame("burst3", 1'b0, 1'b0, 1'b0, 2, 1'b1);
        checkOutput("burst3.ss150", last_ss_low, 150);
        checkOutput("burst3.pop_gap", (read_offs.size() == 3) ? read_offs[2] - read_offs[1] : -1, 48);
        checkOutput("burst3.rx_gap", (rx_offs.size() == 3) ? rx_offs[2] - rx_offs[1] : -1, 48);

        // spi_en dropped mid-byte: first byte completes, second stays queued
        exp_tx    = '{8'h3A, 8'h7E};
        setup_frame(1'b0, 1'b0, 1'b0, 1, 1'b1);
        spi_en = 1'b1;
        wait_edges("en_drop", 5, 1000);
        checkOutput("en_drop.busy_mid", int'(busy), 1);
        spi_en = 1'b0;
        wait_frame("en_drop", 1000);
        checkOutput("en_drop.ss_low", last_ss_low, 36);
        checkOutput("en_drop.reads", reads, 1);
        checkOutput("en_drop.rx_count", rx_seen.size(), 1);
        checkOutput("en_drop.rx0", (rx_seen.size() != 0) ? int'(rx_seen[0]) : -1, 8'h3A);
        checkOutput("en_drop.left", fifo_q.size(), 1);
        checkOutput("en_drop.fifo_empty", int'(fifo_empty), 0);
        spi_en = 1'b1;
        wait_frame("en_drop2", 1000);
        spi_en = 1'b0;
        checkOutput("en_drop2.rx1", (rx_seen.size() > 1) ? int'(rx_seen[1]) : -1, 8'h7E);
        checkOutput("en_drop2.mosi1", (mosi_bytes.size() > 1) ? int'(mosi_bytes[1]) : -1, 8'h7E);

        // Reset mid-frame aborts; restart sends the next queued byte
        exp_tx    = '{8'h5A, 8'hC3};
        setup_frame(1'b0, 1'b0, 1'b0, 1, 1'b1);
        spi_en = 1'b1;
        wait_edges("abort", 9, 1000);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort.ss", int'(ss), 1);
        checkOutput("abort.sclk", int'(sclk), 0);
        checkOutput("abort.mosi", int'(mosi), 0);
        checkOutput("abort.busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort.no_rx", rx_seen.size(), 0);
        wait_frame("restart", 1000);
        spi_en = 1'b0;
        checkOutput("restart.reads", reads, 2);
        checkOutput("restart.rx_count", rx_seen.size(), 1);
        checkOutput("restart.rx0", (rx_seen.size() != 0) ? int'(rx_seen[0]) : -1, 8'hC3);
        checkOutput("restart.mosi0", (mosi_bytes.size() != 0) ? int'(mosi_bytes[0]) : -1, 8'hC3);
        checkOutput("restart.ss_low", last_ss_low, 36);

        // Configuration changes mid-frame are ignored until the next frame
        exp_tx    = '{8'h69};
        setup_frame(1'b0, 1'b0, 1'b0, 1, 1'b1);
        spi_en = 1'b1;
        wait_edges("cfgchg", 4, 1000);
        applyStimulus(1'b1, 1'b1, 1'b1, 5);
        wait_frame("cfgchg", 1000);
        checkOutput("cfgchg.ss_low", last_ss_low, 36);
        checkOutput("cfgchg.rx0", (rx_seen.size() != 0) ? int'(rx_seen[0]) : -1, 8'h69);
        checkOutput("cfgchg.mosi0", (mosi_bytes.size() != 0) ? int'(mosi_bytes[0]) : -1, 8'h69);
        checkOutput("cfgchg.idle_sclk", int'(sclk), 0);
        r0 = reads;
        repeat (20) @(negedge clk);
        checkOutput("empty.reads", reads, r0);
        checkOutput("empty.busy", int'(busy), 0);
        checkOutput("empty.ss", int'(ss), 1);
        spi_en = 1'b0;

        // Randomized frames against the timing/byte model with a non-loopback slave
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 3);
            exp_tx.delete();
            exp_slave.delete();
            for (int k = 0; k < n; k++) begin
                exp_tx.push_back(8'($urandom));
                exp_slave.push_back(8'($urandom));
            end
            run_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
